// File: rtl/alu_uart_sequencer_if.sv
// alu_uart_sequencer_if
//   Bundles the UART receive/transmit handshake and the ALU operand and
//   result signals seen by alu_uart_sequencer.
//   master : the sequencer. It samples the i_* signals and drives the o_* signals.
//   slave  : the environment (UART rx/tx and ALU). It drives i_* and samples o_*.
// Parameters: N_BITS (byte/operand width), N_OP (ALU opcode width).
interface alu_uart_sequencer_if #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
);
    logic [N_BITS-1:0] i_rx_data;     // received byte, valid with i_rx_done
    logic              i_rx_done;     // one-cycle pulse per received byte
    logic [N_BITS-1:0] i_alu_result;  // combinational ALU output
    logic              i_tx_busy;     // transmitter busy
    logic              i_tx_done;     // one-cycle pulse at end of a tx byte
    logic [N_BITS-1:0] o_A;           // ALU operand A
    logic [N_BITS-1:0] o_B;           // ALU operand B
    logic [N_OP-1:0]   o_Op;          // ALU opcode
    logic [N_BITS-1:0] o_tx_data;     // byte to transmit
    logic              o_tx_start;    // one-cycle transmit request
    logic              o_drop;        // received byte discarded
    logic              o_timeout;     // partial frame abandoned
    logic              o_busy;        // frame in progress

    modport master (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_busy, i_tx_done,
        output o_A, o_B, o_Op, o_tx_data, o_tx_start, o_drop, o_timeout, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_busy, i_tx_done,
        input  o_A, o_B, o_Op, o_tx_data, o_tx_start, o_drop, o_timeout, o_busy
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
//   Receives three UART bytes in order (operand A, operand B, opcode). It then
//   presents them to a combinational ALU, captures the result and hands that
//   result to the UART transmitter.
//   A counter limits the gap between the bytes of one frame. When the gap is
//   too long the partial frame is abandoned, so a lost byte cannot shift
//   every later frame out of step.
//   Bytes that arrive while a result is being produced or sent are dropped
//   and reported.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset
//   bus     : alu_uart_sequencer_if.master (UART rx/tx handshake, ALU operands/result)
// Parameters:
//   N_BITS      : byte and operand width
//   N_OP        : opcode width (low bits of the opcode byte)
//   TIMEOUT_CYC : allowed cycles between bytes of one frame (0 = no timeout)
// Optional build macro:
//   ALU_OP_CHECK_EN : check the opcode byte against the supported operations.
//                     An unknown opcode sends 0xFF instead of a result.
// All outputs are registered.
module alu_uart_sequencer #(
    parameter int N_BITS      = 8,
    parameter int N_OP        = 6,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    alu_uart_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
    } state_t;

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 2);
    localparam bit             TO_EN    = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [N_BITS-1:0]  a_n, b_n, tx_data_n;
    logic [N_OP-1:0]    op_n;
    logic               start_n, drop_n, timeout_n, busy_n;
    logic               expire;

`ifdef ALU_OP_CHECK_EN
    function automatic logic op_valid(input logic [N_BITS-1:0] b);
        case (b)
            N_BITS'(8'h20), N_BITS'(8'h22), N_BITS'(8'h24), N_BITS'(8'h25),
            N_BITS'(8'h26), N_BITS'(8'h27), N_BITS'(8'h03), N_BITS'(8'h02):
                op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    endfunction
`endif

    // Expiry happens on the edge where the counter would reach TIMEOUT_CYC,
    // so the pulse appears TIMEOUT_CYC cycles after the last accepted byte.
    assign expire = TO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        a_n       = bus.o_A;
        b_n       = bus.o_B;
        op_n      = bus.o_Op;
        tx_data_n = bus.o_tx_data;
        start_n   = 1'b0;
        drop_n    = 1'b0;
        timeout_n = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    a_n     = bus.i_rx_data;
                    cnt_n   = '0;
                    state_n = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.i_rx_done) begin
                    b_n     = bus.i_rx_data;
                    cnt_n   = '0;
                    state_n = WAIT_OP;
                end else if (expire) begin
                    timeout_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = WAIT_A;
                end else if (TO_EN && cnt_q != CNT_MAX) begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    cnt_n = '0;
`ifdef ALU_OP_CHECK_EN
                    if (op_valid(bus.i_rx_data)) begin
                        op_n    = bus.i_rx_data[N_OP-1:0];
                        state_n = EXEC;
                    end else begin
                        // Unknown opcode: skip the ALU and report the error byte.
                        tx_data_n = '1;
                        state_n   = SEND;
                    end
`else
                    op_n    = bus.i_rx_data[N_OP-1:0];
                    state_n = EXEC;
`endif
                end else if (expire) begin
                    timeout_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = WAIT_A;
                end else if (TO_EN && cnt_q != CNT_MAX) begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                // The operands have settled during this cycle. Capture the
                // result. If the transmitter is idle, also request the send now.
                // This places o_tx_start in the cycle after EXEC.
                drop_n    = bus.i_rx_done;
                tx_data_n = bus.i_alu_result;
                if (!bus.i_tx_busy) begin
                    start_n = 1'b1;
                    state_n = WAIT_TX;
                end else begin
                    state_n = SEND;
                end
            end
            SEND: begin
                drop_n = bus.i_rx_done;
                if (!bus.i_tx_busy) begin
                    start_n = 1'b1;
                    state_n = WAIT_TX;
                end
            end
            WAIT_TX: begin
                drop_n = bus.i_rx_done;
                if (bus.i_tx_done) state_n = WAIT_A;
            end
            default: state_n = WAIT_A;
        endcase
        busy_n = (state_n != WAIT_A);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= WAIT_A;
            cnt_q          <= '0;
            bus.o_A        <= '0;
            bus.o_B        <= '0;
            bus.o_Op       <= '0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_drop     <= 1'b0;
            bus.o_timeout  <= 1'b0;
            bus.o_busy     <= 1'b0;
        end else begin
            state_q        <= state_n;
            cnt_q          <= cnt_n;
            bus.o_A        <= a_n;
            bus.o_B        <= b_n;
            bus.o_Op       <= op_n;
            bus.o_tx_data  <= tx_data_n;
            bus.o_tx_start <= start_n;
            bus.o_drop     <= drop_n;
            bus.o_timeout  <= timeout_n;
            bus.o_busy     <= busy_n;
        end
    end
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Testbench for alu_uart_sequencer. It uses a small ALU model and table-driven
// frames, plus hand-written sequences for timeout, drop and reset cases.
module tb_alu_uart_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   drop_cnt = 0;
    int   to_cnt = 0;

    always #5 clk = ~clk;

    alu_uart_sequencer_if #(.N_BITS(8), .N_OP(6)) bus ();

    alu_uart_sequencer #(.N_BITS(8), .N_OP(6), .TIMEOUT_CYC(100)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    // Reference ALU (funct-style opcodes)
    always_comb begin
        case (bus.o_Op)
            6'h20:   bus.i_alu_result = bus.o_A + bus.o_B;
            6'h22:   bus.i_alu_result = bus.o_A - bus.o_B;
            6'h24:   bus.i_alu_result = bus.o_A & bus.o_B;
            6'h25:   bus.i_alu_result = bus.o_A | bus.o_B;
            6'h26:   bus.i_alu_result = bus.o_A ^ bus.o_B;
            6'h27:   bus.i_alu_result = ~(bus.o_A | bus.o_B);
            6'h03:   bus.i_alu_result = $signed(bus.o_A) >>> bus.o_B;
            6'h02:   bus.i_alu_result = bus.o_A >> bus.o_B;
            default: bus.i_alu_result = 8'h00;
        endcase
    end

    always @(negedge clk) begin
        if (bus.o_tx_start) start_cnt++;
        if (bus.o_drop)     drop_cnt++;
        if (bus.o_timeout)  to_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse();
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int busy_cyc, input logic [5:0] eop, input logic [7:0] etx,
                             input string name);
        int s0;
        s0 = start_cnt;
        bus.i_tx_busy = (busy_cyc > 0);
        send_byte(a);
        idle(2);
        send_byte(b);
        idle(1);
        send_byte(op);
        check({name, ".A"}, bus.o_A, a);
        check({name, ".B"}, bus.o_B, b);
        check({name, ".Op"}, bus.o_Op, eop);
        if (busy_cyc > 0) begin
            idle(busy_cyc);
            check({name, ".held_no_start"}, start_cnt, s0);
            bus.i_tx_busy = 1'b0;
        end
        @(negedge clk);
        check({name, ".tx_start"}, bus.o_tx_start, 1'b1);
        check({name, ".tx_data"}, bus.o_tx_data, etx);
        idle(3);
        check({name, ".one_start"}, start_cnt, s0 + 1);
        tx_done_pulse();
        check({name, ".idle_after"}, bus.o_busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         busy;
        logic [5:0] eop;
        logic [7:0] etx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int d0;
        int t0;
        int s0;
        vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, busy: 0,  eop: 6'h20, etx: 8'h08};
        vecs[1] = '{a: 8'h03, b: 8'h05, op: 8'h22, busy: 30, eop: 6'h22, etx: 8'hFE};
        vecs[2] = '{a: 8'h80, b: 8'h02, op: 8'h03, busy: 0,  eop: 6'h03, etx: 8'hE0};
        vecs[3] = '{a: 8'h80, b: 8'h02, op: 8'h02, busy: 5,  eop: 6'h02, etx: 8'h20};
        vecs[4] = '{a: 8'h0C, b: 8'h0A, op: 8'h27, busy: 0,  eop: 6'h27, etx: 8'hF1};
        vecs[5] = '{a: 8'h0F, b: 8'h0F, op: 8'h24, busy: 0,  eop: 6'h24, etx: 8'h0F};

        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_busy = 1'b0;
        bus.i_tx_done = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst.A", bus.o_A, 0);
        check("rst.B", bus.o_B, 0);
        check("rst.Op", bus.o_Op, 0);
        check("rst.tx_data", bus.o_tx_data, 0);
        check("rst.flags", {bus.o_tx_start, bus.o_drop, bus.o_timeout, bus.o_busy}, 4'b0000);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].busy, vecs[i].eop, vecs[i].etx,
                      $sformatf("vec%0d", i));

        // Timeout: a lone A byte, then silence
        t0 = to_cnt;
        send_byte(8'h11);
        n = 0;
        while (n < 300 && !bus.o_timeout) begin
            @(negedge clk);
            n++;
        end
        check("to.cycles", n, 100);
        check("to.busy", bus.o_busy, 1'b0);
        check("to.stale_A", bus.o_A, 8'h11);
        @(negedge clk);
        check("to.one_pulse", to_cnt, t0 + 1);
        run_frame(8'h0F, 8'hF0, 8'h24, 0, 6'h24, 8'h00, "after_to");

        // B byte lands on the exact expiry cycle: the byte is accepted.
        t0 = to_cnt;
        s0 = start_cnt;
        send_byte(8'h21);
        idle(98);
        send_byte(8'h01);
        send_byte(8'h20);
        check("simul.no_timeout", to_cnt, t0);
        @(negedge clk);
        check("simul.tx_start", bus.o_tx_start, 1'b1);
        check("simul.tx_data", bus.o_tx_data, 8'h22);
        tx_done_pulse();
        check("simul.starts", start_cnt, s0 + 1);

        // Drop: a byte received during WAIT_TX
        d0 = drop_cnt;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        idle(2);
        send_byte(8'h55);
        check("drop.pulse", bus.o_drop, 1'b1);
        check("drop.A_kept", bus.o_A, 8'h05);
        tx_done_pulse();
        check("drop.count", drop_cnt, d0 + 1);
        run_frame(8'h0C, 8'h0A, 8'h26, 0, 6'h26, 8'h06, "after_drop");

        // A late tx_done in WAIT_A is ignored.
        tx_done_pulse();
        check("late_done.busy", bus.o_busy, 1'b0);

        // Reset after the B byte
        s0 = start_cnt;
        send_byte(8'h77);
        send_byte(8'h66);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst.outs", {bus.o_A, bus.o_B, bus.o_Op, bus.o_tx_data}, 32'h0);
        check("mid_rst.flags", {bus.o_tx_start, bus.o_drop, bus.o_timeout, bus.o_busy}, 4'b0000);
        rst = 1'b0;
        idle(5);
        check("mid_rst.no_start", start_cnt, s0);
        run_frame(8'h0C, 8'h0A, 8'h25, 0, 6'h25, 8'h0E, "after_rst");

        // Opcode byte 0x3F
`ifdef ALU_OP_CHECK_EN
        run_frame(8'h12, 8'h34, 8'h3F, 0, 6'h25, 8'hFF, "bad_op");
`else
        run_frame(8'h12, 8'h34, 8'h3F, 0, 6'h3F, 8'h00, "raw_op");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
